// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA types and default raster timing
//
// Shared by the sync generator and the capture block.
//   rgb_t       : 24-bit packed pixel {red, green, blue}
//   cap_state_t : capture lock FSM states
//   H_TOTAL     : clocks per line (hsync rise to hsync rise)
//   V_TOTAL     : lines per frame (vsync rise to vsync rise)
package vga_pkg;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 526;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } cap_state_t;

endpackage

// File: rtl/vga_edge_det.sv
// rtl/vga_edge_det.sv - input register plus rising-edge detect for a sync bit
//
// Ports:
//   clk  in  pixel clock
//   rst  in  synchronous active-high reset
//   d    in  raw sync pin
//   rise out high for the one registered (S1) sample in which d first reads 1
module vga_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;
    logic q_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= 1'b0;
            q_d <= 1'b0;
        end else begin
            q   <= d;
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA raster lock checker and window capture into a framebuffer
//
// Ports:
//   clk, rst                     pixel clock, synchronous active-high reset
//   i_hsync, i_vsync             active-high syncs
//   i_red, i_green, i_blue       pixel colour
//   i_capture_en                 sampled at each vsync rise; arms capture of that frame
//   o_we, o_addr, o_wdata        framebuffer write port (one write per clock, no handshake)
//   o_locked                     raster verified, capture permitted
//   o_frame_done                 pulse the cycle after the last window write
//   o_err, o_err_cnt             violation pulse and saturating violation count
module vga_capture #(
    parameter int H_TOTAL   = vga_pkg::H_TOTAL,
    parameter int V_TOTAL   = vga_pkg::V_TOTAL,
    parameter int WIN_X0    = 320,
    parameter int WIN_Y0    = 121,
    parameter int WIN_W     = 199,
    parameter int WIN_H     = 199,
    parameter int BASE_ADDR = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    input  logic        i_capture_en,
    output logic        o_we,
    output logic [31:0] o_addr,
    output logic [23:0] o_wdata,
    output logic        o_locked,
    output logic        o_frame_done,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);

    import vga_pkg::*;

    localparam logic [9:0]  X_MAX  = 10'(H_TOTAL);
    localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  WX0    = 10'(WIN_X0);
    localparam logic [9:0]  WX1    = 10'(WIN_X0 + WIN_W - 1);
    localparam logic [9:0]  WY0    = 10'(WIN_Y0);
    localparam logic [9:0]  WY1    = 10'(WIN_Y0 + WIN_H - 1);
    localparam logic [31:0] BASE   = 32'(BASE_ADDR);

    // S1 stage
    logic hs_rise;
    logic vs_rise;
    rgb_t rgb_s1;
    logic cap_en_s1;

    vga_edge_det u_hs_det (
        .clk  (clk),
        .rst  (rst),
        .d    (i_hsync),
        .rise (hs_rise)
    );

    vga_edge_det u_vs_det (
        .clk  (clk),
        .rst  (rst),
        .d    (i_vsync),
        .rise (vs_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_s1    <= '0;
            cap_en_s1 <= 1'b0;
        end else begin
            rgb_s1    <= '{red: i_red, green: i_green, blue: i_blue};
            cap_en_s1 <= i_capture_en;
        end
    end

    // Coordinates: *_prev hold the previous S1 sample's position, *_cur the
    // position of the sample being processed now.
    logic [9:0] x_prev, x_cur;
    logic [9:0] y_prev, y_cur;

    always_comb begin
        x_cur = x_prev;
        if (hs_rise || vs_rise) begin
            x_cur = '0;
        end else if (x_prev != X_MAX) begin
            x_cur = x_prev + 10'd1;
        end

        y_cur = y_prev;
        if (vs_rise) begin
            y_cur = '0;
        end else if (hs_rise) begin
            y_cur = y_prev + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_prev <= '0;
            y_prev <= '0;
        end else begin
            x_prev <= x_cur;
            y_prev <= y_cur;
        end
    end

    // Timing checks. x saturates at X_MAX, so reaching it means the line ran
    // long without an hsync rise.
    cap_state_t state, state_next;
    logic line_bad, timeout, frame_bad, violation, frame_start;

    always_comb begin
        line_bad    = hs_rise && (x_prev != X_MAX - 10'd1);
        timeout     = (x_cur == X_MAX);
        frame_bad   = vs_rise && (!hs_rise || (y_prev != Y_LAST));
        violation   = (state != SEARCH) && (line_bad || timeout || frame_bad);
        frame_start = (state != SEARCH) && vs_rise && !violation;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            SEARCH: begin
                if (vs_rise) begin
                    state_next = VERIFY;
                end
            end
            VERIFY, LOCKED: begin
                if (violation) begin
                    state_next = SEARCH;
                end else if (vs_rise) begin
                    state_next = LOCKED;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_locked = (state == LOCKED);
    end

    // Window capture
    logic        cap_arm;
    logic [31:0] wr_ptr;
    logic        in_win, last_px, wr, done_pend;

    always_comb begin
        in_win  = (x_cur >= WX0) && (x_cur <= WX1) && (y_cur >= WY0) && (y_cur <= WY1);
        last_px = (x_cur == WX1) && (y_cur == WY1);
        wr      = cap_arm && (state == LOCKED) && in_win && !violation;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_arm      <= 1'b0;
            wr_ptr       <= BASE;
            o_we         <= 1'b0;
            o_addr       <= '0;
            o_wdata      <= '0;
            done_pend    <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
            o_err_cnt    <= '0;
        end else begin
            o_we         <= wr;
            o_err        <= violation;
            done_pend    <= wr && last_px;
            o_frame_done <= done_pend;

            if (wr) begin
                o_addr  <= wr_ptr;
                o_wdata <= rgb_s1;
                wr_ptr  <= wr_ptr + 32'd1;
            end

            if (violation) begin
                cap_arm <= 1'b0;
                if (o_err_cnt != 8'hFF) begin
                    o_err_cnt <= o_err_cnt + 8'd1;
                end
            end else if (frame_start) begin
                cap_arm <= cap_en_s1;
                wr_ptr  <= BASE;
            end else if (wr && last_px) begin
                cap_arm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - self-checking bench for vga_capture on a reduced raster
module tb_vga_capture;

    localparam int H         = 40;
    localparam int V         = 20;
    localparam int X0        = 10;
    localparam int Y0        = 5;
    localparam int W         = 8;
    localparam int WH        = 6;
    localparam int BASE      = 24;
    localparam int HS_W      = 4;
    localparam int VS_L      = 2;
    localparam int STALL_LEN = 1000;

    localparam int K_GOOD  = 0;
    localparam int K_SHORT = 1;
    localparam int K_STALL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_hsync = 1'b0;
    logic        i_vsync = 1'b0;
    logic [7:0]  i_red = '0;
    logic [7:0]  i_green = '0;
    logic [7:0]  i_blue = '0;
    logic        i_capture_en = 1'b0;
    logic        o_we;
    logic [31:0] o_addr;
    logic [23:0] o_wdata;
    logic        o_locked;
    logic        o_frame_done;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    vga_capture #(
        .H_TOTAL   (H),
        .V_TOTAL   (V),
        .WIN_X0    (X0),
        .WIN_Y0    (Y0),
        .WIN_W     (W),
        .WIN_H     (WH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .i_red        (i_red),
        .i_green      (i_green),
        .i_blue       (i_blue),
        .i_capture_en (i_capture_en),
        .o_we         (o_we),
        .o_addr       (o_addr),
        .o_wdata      (o_wdata),
        .o_locked     (o_locked),
        .o_frame_done (o_frame_done),
        .o_err        (o_err),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [23:0] data;
    } wr_t;

    typedef struct {
        int kind;
        int fline;
        bit cap_en;
        bit exp_cap;
        int rst_idx;
        int exp_writes;
        int exp_done;
        int exp_errs;
        bit exp_locked;
        int exp_cnt;
    } row_t;

    wr_t  q[$];
    row_t tbl[12];

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int done_seen = 0;
    int err_seen = 0;
    int exp_err_cyc = -1;
    int exp_done_cyc = -1;
    int rst_chk_cyc = -1;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("write_missing_cyc", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (o_we) begin
                wr_seen++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected actual addr=%0d at cycle %0d required no write", o_addr, cyc);
                end else begin
                    e = q.pop_front();
                    chk("wr_cyc", cyc, e.cyc);
                    chk("wr_addr", o_addr, e.addr);
                    chk("wr_data", o_wdata, e.data);
                end
            end
            if (o_frame_done) begin
                done_seen++;
                chk("done_cyc", cyc, exp_done_cyc);
            end
            if (o_err) begin
                err_seen++;
                chk("err_cyc", cyc, exp_err_cyc);
                chk("locked_at_err", o_locked, 1'b0);
            end
            if (cyc == rst_chk_cyc) begin
                chk("rst_we", o_we, 1'b0);
                chk("rst_addr", o_addr, 32'd0);
                chk("rst_wdata", o_wdata, 24'd0);
                chk("rst_locked", o_locked, 1'b0);
                chk("rst_done", o_frame_done, 1'b0);
                chk("rst_err", o_err, 1'b0);
                chk("rst_err_cnt", o_err_cnt, 8'd0);
            end
        end
    end

    task automatic drive(input bit hs, input bit vs, input logic [23:0] px);
        @(posedge clk);
        #1;
        i_hsync = hs;
        i_vsync = vs;
        {i_red, i_green, i_blue} = px;
        rst = 1'b0;
    endtask

    task automatic drive_frame(input row_t r);
        int          ptr;
        int          idx;
        int          len;
        bit          ab;
        logic [23:0] px;
        i_capture_en = r.cap_en;
        ptr = BASE;
        idx = 0;
        ab  = 1'b0;
        for (int y = 0; y < V; y++) begin
            len = H;
            if (r.kind == K_SHORT && y == r.fline) len = H - 1;
            if (r.kind == K_STALL && y == r.fline) len = STALL_LEN;
            for (int x = 0; x < len; x++) begin
                px = {x[7:0], y[7:0], 8'h5A};
                drive(x < HS_W, y < VS_L, px);
                if (r.kind == K_SHORT && y == r.fline + 1 && x == 0) begin
                    exp_err_cyc = cyc + 2;
                    ab = 1'b1;
                end
                if (r.kind == K_STALL && y == r.fline && x == H) begin
                    exp_err_cyc = cyc + 2;
                    ab = 1'b1;
                end
                if (r.exp_cap && !ab && x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + WH) begin
                    if (idx == r.rst_idx) begin
                        rst = 1'b1;
                        void'(q.pop_back());
                        rst_chk_cyc = cyc + 1;
                        ab = 1'b1;
                    end else begin
                        q.push_back('{cyc + 2, ptr, px});
                        ptr++;
                        if (idx == W * WH - 1) exp_done_cyc = cyc + 3;
                    end
                    idx++;
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int w0, d0, e0;

        //            kind     fl cen cap rst  wr  dn er lk cnt
        tbl[0]  = '{K_GOOD,  0, 1, 0, -1,  0, 0, 0, 0, 0};
        tbl[1]  = '{K_GOOD,  0, 1, 1, -1, 48, 1, 0, 1, 0};
        tbl[2]  = '{K_SHORT, 6, 1, 1, -1, 16, 0, 1, 0, 1};
        tbl[3]  = '{K_GOOD,  0, 1, 0, -1,  0, 0, 0, 0, 1};
        tbl[4]  = '{K_GOOD,  0, 0, 0, -1,  0, 0, 0, 1, 1};
        tbl[5]  = '{K_GOOD,  0, 1, 1, -1, 48, 1, 0, 1, 1};
        tbl[6]  = '{K_STALL, 2, 1, 1, -1,  0, 0, 1, 0, 2};
        tbl[7]  = '{K_GOOD,  0, 1, 0, -1,  0, 0, 0, 0, 2};
        tbl[8]  = '{K_GOOD,  0, 1, 1, -1, 48, 1, 0, 1, 2};
        tbl[9]  = '{K_GOOD,  0, 1, 1, 20, 19, 0, 0, 0, 0};
        tbl[10] = '{K_GOOD,  0, 1, 0, -1,  0, 0, 0, 0, 0};
        tbl[11] = '{K_GOOD,  0, 1, 1, -1, 48, 1, 0, 1, 0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_we", o_we, 1'b0);
        chk("init_addr", o_addr, 32'd0);
        chk("init_wdata", o_wdata, 24'd0);
        chk("init_locked", o_locked, 1'b0);
        chk("init_done", o_frame_done, 1'b0);
        chk("init_err", o_err, 1'b0);
        chk("init_err_cnt", o_err_cnt, 8'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            w0 = wr_seen;
            d0 = done_seen;
            e0 = err_seen;
            drive_frame(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d_writes", i), wr_seen - w0, tbl[i].exp_writes);
            chk($sformatf("row%0d_done", i), done_seen - d0, tbl[i].exp_done);
            chk($sformatf("row%0d_errs", i), err_seen - e0, tbl[i].exp_errs);
            chk($sformatf("row%0d_locked", i), o_locked, tbl[i].exp_locked);
            chk($sformatf("row%0d_err_cnt", i), o_err_cnt, tbl[i].exp_cnt);
        end

        // Rapid bad lines: each vsync rise re-enters checking and the next
        // hsync rise two clocks later is a short line.
        i_capture_en = 1'b0;
        e0 = err_seen;
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, 1'b1, 24'h0);
            drive(1'b0, 1'b0, 24'h0);
            drive(1'b1, 1'b0, 24'h0);
            exp_err_cyc = cyc + 2;
            drive(1'b0, 1'b0, 24'h0);
        end
        repeat (4) drive(1'b0, 1'b0, 24'h0);
        @(negedge clk);
        chk("sat_err_pulses", err_seen - e0, 300);
        chk("sat_err_cnt", o_err_cnt, 8'd255);
        chk("sat_locked", o_locked, 1'b0);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
